dmem_port_arbiter: RTL and testbench

- Shares the single byte-addressed data-memory port between the pipeline MEM stage (CPU) and a DMA/loader requester.
- The memory has a combinational read and a posedge write. The arbiter therefore issues at most one access per cycle, stalls the pipeline on loss, and returns DMA read data registered.
- Sits between the EX/MEM register, the DMA engine and data_mem.
- Arbitration is CPU-first. A starvation counter and a bounded DMA burst lock guarantee progress for both requesters.

---
 rtl/dmem_port_arbiter_pkg.sv | 22 ++
 rtl/dmem_port_arbiter_if.sv | 44 ++++
 rtl/dmem_port_mux.sv | 46 ++++
 rtl/dmem_port_arbiter.sv | 103 ++++++++++
 tb/tb_dmem_port_arbiter.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// rtl/dmem_port_arbiter_pkg.sv - shared state, select and funct3 encodings for the data-memory port
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DMA_LOCK = 2'd1
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_CPU  = 2'd1,
    SEL_DMA  = 2'd2
  } sel_e;

  // Size/sign codes shared with data_mem and the control unit.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - CPU, DMA and memory-side signals of the shared data-memory port
interface dmem_port_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [2:0]  cpu_funct3;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;

  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [2:0]  dma_funct3;
  logic        dma_last;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_funct3;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;

  // Requesters and memory drive the master side; the arbiter is the slave.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_funct3,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_funct3, dma_last,
    output mem_rdata,
    input  cpu_stall, cpu_rdata, dma_gnt, dma_rvalid, dma_rdata,
    input  mem_addr, mem_wdata, mem_funct3, mem_we, mem_re
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_funct3,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_funct3, dma_last,
    input  mem_rdata,
    output cpu_stall, cpu_rdata, dma_gnt, dma_rvalid, dma_rdata,
    output mem_addr, mem_wdata, mem_funct3, mem_we, mem_re
  );
endinterface

// File: rtl/dmem_port_mux.sv
// rtl/dmem_port_mux.sv - steers the selected requester onto the memory bus
module dmem_port_mux
  import dmem_port_arbiter_pkg::*;
(
  input  sel_e        i_sel,
  input  logic        i_cpu_we,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  input  logic [2:0]  i_cpu_funct3,
  input  logic        i_dma_we,
  input  logic [31:0] i_dma_addr,
  input  logic [31:0] i_dma_wdata,
  input  logic [2:0]  i_dma_funct3,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [2:0]  o_mem_funct3,
  output logic        o_mem_we,
  output logic        o_mem_re
);

  always_comb begin
    o_mem_addr   = '0;
    o_mem_wdata  = '0;
    o_mem_funct3 = '0;
    o_mem_we     = 1'b0;
    o_mem_re     = 1'b0;
    case (i_sel)
      SEL_CPU: begin
        o_mem_addr   = i_cpu_addr;
        o_mem_wdata  = i_cpu_wdata;
        o_mem_funct3 = i_cpu_funct3;
        o_mem_we     = i_cpu_we;
        o_mem_re     = !i_cpu_we;
      end
      SEL_DMA: begin
        o_mem_addr   = i_dma_addr;
        o_mem_wdata  = i_dma_wdata;
        o_mem_funct3 = i_dma_funct3;
        o_mem_we     = i_dma_we;
        o_mem_re     = !i_dma_we;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - CPU-first data-memory port arbiter with DMA starvation guard and bounded burst lock
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 8,
  parameter int CW        = 4
) (
  input  logic               clk,
  input  logic               rst,
  dmem_port_arbiter_if.slave bus
);

  state_e         r_state, w_state_nxt;
  logic [CW-1:0]  r_wait_cnt, w_wait_nxt;
  logic [CW-1:0]  r_beat_cnt, w_beat_nxt, w_beat_inc;
  logic           w_dma_win, w_cpu_win;
  sel_e           w_sel;
  logic           r_rvalid;
  logic [31:0]    r_rdata;

  // Reset gates both winners so the memory bus is quiet while rst is high.
  always_comb begin
    w_dma_win = 1'b0;
    w_cpu_win = 1'b0;
    w_sel     = SEL_NONE;
    if (!rst) begin
      if (bus.dma_req && (r_state == ST_DMA_LOCK || !bus.cpu_req ||
                          r_wait_cnt == CW'(MAX_WAIT)))
        w_dma_win = 1'b1;
      else if (bus.cpu_req)
        w_cpu_win = 1'b1;
    end
    if (w_dma_win)
      w_sel = SEL_DMA;
    else if (w_cpu_win)
      w_sel = SEL_CPU;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat_cnt;
    w_wait_nxt  = r_wait_cnt;
    w_beat_inc  = (r_state == ST_IDLE) ? CW'(1) : r_beat_cnt + CW'(1);
    if (w_dma_win) begin
      if (bus.dma_last || w_beat_inc == CW'(BURST_MAX)) begin
        w_state_nxt = ST_IDLE;
        w_beat_nxt  = '0;
      end else begin
        w_state_nxt = ST_DMA_LOCK;
        w_beat_nxt  = w_beat_inc;
      end
    end else if (r_state == ST_DMA_LOCK && !bus.dma_req) begin
      w_state_nxt = ST_IDLE;
      w_beat_nxt  = '0;
    end
    if (w_dma_win || !bus.dma_req)
      w_wait_nxt = '0;
    else if (r_wait_cnt != CW'(MAX_WAIT))
      w_wait_nxt = r_wait_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_beat_cnt <= '0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_rvalid   <= w_dma_win && !bus.dma_we;
      if (w_dma_win && !bus.dma_we)
        r_rdata <= bus.mem_rdata;
    end
  end

  assign bus.dma_gnt    = w_dma_win;
  assign bus.cpu_stall  = w_dma_win && bus.cpu_req;
  assign bus.cpu_rdata  = w_cpu_win ? bus.mem_rdata : 32'd0;
  assign bus.dma_rvalid = r_rvalid;
  assign bus.dma_rdata  = r_rdata;

  dmem_port_mux u_mux (
    .i_sel        (w_sel),
    .i_cpu_we     (bus.cpu_we),
    .i_cpu_addr   (bus.cpu_addr),
    .i_cpu_wdata  (bus.cpu_wdata),
    .i_cpu_funct3 (bus.cpu_funct3),
    .i_dma_we     (bus.dma_we),
    .i_dma_addr   (bus.dma_addr),
    .i_dma_wdata  (bus.dma_wdata),
    .i_dma_funct3 (bus.dma_funct3),
    .o_mem_addr   (bus.mem_addr),
    .o_mem_wdata  (bus.mem_wdata),
    .o_mem_funct3 (bus.mem_funct3),
    .o_mem_we     (bus.mem_we),
    .o_mem_re     (bus.mem_re)
  );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - scoreboard bench for dmem_port_arbiter
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  localparam int W_NONE = 0;
  localparam int W_CPU  = 1;
  localparam int W_DMA  = 2;

  typedef struct {
    logic        dma;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic        we;
    logic        stall;
    logic [31:0] crd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t        acc_q[$];
  logic [31:0] rd_q[$];

  dmem_port_arbiter_if bus ();

  dmem_port_arbiter #(.MAX_WAIT(4), .BURST_MAX(8), .CW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus; win is the hand-derived winner for this cycle.
  task automatic cyc(input logic r, input logic creq, input logic cwe, input logic [31:0] caddr,
                     input logic dreq, input logic dwe, input logic [31:0] daddr,
                     input logic dlast, input logic [31:0] rdata, input int win);
    exp_t e;
    rst            = r;
    bus.cpu_req    = creq;
    bus.cpu_we     = cwe;
    bus.cpu_addr   = caddr;
    bus.cpu_wdata  = caddr ^ 32'hA5A5_0000;
    bus.cpu_funct3 = F3_W;
    bus.dma_req    = dreq;
    bus.dma_we     = dwe;
    bus.dma_addr   = daddr;
    bus.dma_wdata  = daddr ^ 32'h5A5A_0000;
    bus.dma_funct3 = F3_H;
    bus.dma_last   = dlast;
    bus.mem_rdata  = rdata;
    if (win == W_CPU) begin
      e.dma = 1'b0; e.addr = caddr; e.wdata = caddr ^ 32'hA5A5_0000; e.f3 = F3_W;
      e.we = cwe; e.stall = 1'b0; e.crd = rdata;
      acc_q.push_back(e);
    end else if (win == W_DMA) begin
      e.dma = 1'b1; e.addr = daddr; e.wdata = daddr ^ 32'h5A5A_0000; e.f3 = F3_H;
      e.we = dwe; e.stall = creq; e.crd = 32'd0;
      acc_q.push_back(e);
      if (!dwe) rd_q.push_back(rdata);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [31:0] rexp;
    if (bus.mem_re || bus.mem_we) begin
      if (acc_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_access actual=addr %h expected=none t=%0t", bus.mem_addr, $time);
      end else begin
        e = acc_q.pop_front();
        chk("dma_gnt",   {31'd0, bus.dma_gnt},   {31'd0, e.dma});
        chk("mem_addr",  bus.mem_addr,           e.addr);
        chk("mem_wdata", bus.mem_wdata,          e.wdata);
        chk("mem_f3",    {29'd0, bus.mem_funct3}, {29'd0, e.f3});
        chk("mem_we",    {31'd0, bus.mem_we},    {31'd0, e.we});
        chk("mem_re",    {31'd0, bus.mem_re},    {31'd0, !e.we});
        chk("cpu_stall", {31'd0, bus.cpu_stall}, {31'd0, e.stall});
        chk("cpu_rdata", bus.cpu_rdata,          e.crd);
      end
    end
    if (bus.dma_rvalid) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid actual=%h expected=none t=%0t", bus.dma_rdata, $time);
      end else begin
        rexp = rd_q.pop_front();
        chk("dma_rdata", bus.dma_rdata, rexp);
      end
    end
    if (!bus.cpu_req)
      chk("stall_no_req", {31'd0, bus.cpu_stall}, 32'd0);
  end

  initial begin
    // Reset with both requesters active: bus must stay quiet.
    cyc(1, 1, 0, 32'h10, 1, 0, 32'h100, 0, 32'hFFFF_FFFF, W_NONE);
    cyc(1, 1, 0, 32'h10, 1, 0, 32'h100, 0, 32'hFFFF_FFFF, W_NONE);
    chk("rst_dma_gnt",    {31'd0, bus.dma_gnt},    32'd0);
    chk("rst_cpu_stall",  {31'd0, bus.cpu_stall},  32'd0);
    chk("rst_mem_we",     {31'd0, bus.mem_we},     32'd0);
    chk("rst_mem_re",     {31'd0, bus.mem_re},     32'd0);
    chk("rst_dma_rvalid", {31'd0, bus.dma_rvalid}, 32'd0);
    chk("rst_dma_rdata",  bus.dma_rdata,           32'd0);

    // CPU-only load.
    cyc(0, 1, 0, 32'h10, 0, 0, 32'h0, 0, 32'hDEAD_BEEF, W_CPU);
    // DMA-only single-beat read, then an idle cycle carrying the rvalid pulse.
    cyc(0, 0, 0, 32'h0, 1, 0, 32'h100, 1, 32'h1234_5678, W_DMA);
    cyc(0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, W_NONE);

    // Both requesting: CPU x4, then DMA forced in; then DMA abort lets CPU in.
    for (int i = 0; i < 4; i++)
      cyc(0, 1, 0, 32'h14, 1, 0, 32'h104, 0, 32'h1111_0000 + i, W_CPU);
    cyc(0, 1, 0, 32'h14, 1, 0, 32'h104, 0, 32'h2222_2222, W_DMA);
    cyc(0, 1, 1, 32'h18, 0, 0, 32'h0, 0, 32'h3333_3333, W_CPU);

    // Three-beat write burst under constant CPU pressure.
    for (int i = 0; i < 4; i++)
      cyc(0, 1, 0, 32'h30, 1, 1, 32'h200, 0, 32'h4444_0000 + i, W_CPU);
    cyc(0, 1, 0, 32'h30, 1, 1, 32'h200, 0, 32'h0, W_DMA);
    cyc(0, 1, 0, 32'h30, 1, 1, 32'h204, 0, 32'h0, W_DMA);
    cyc(0, 1, 0, 32'h30, 1, 1, 32'h208, 1, 32'h0, W_DMA);
    cyc(0, 1, 0, 32'h34, 0, 0, 32'h0, 0, 32'h5555_5555, W_CPU);

    // Unterminated read burst: exactly 8 grants, then forced release.
    for (int i = 0; i < 8; i++)
      cyc(0, 0, 0, 32'h0, 1, 0, 32'h300 + 4 * i, 0, 32'hC0DE_0000 + i, W_DMA);
    for (int i = 0; i < 4; i++)
      cyc(0, 1, 0, 32'h40, 1, 0, 32'h400, 0, 32'h6666_0000 + i, W_CPU);
    cyc(0, 1, 0, 32'h40, 1, 0, 32'h400, 1, 32'h7777_7777, W_DMA);
    cyc(0, 1, 0, 32'h44, 0, 0, 32'h0, 0, 32'h8888_8888, W_CPU);

    // Reset on the second beat of a locked burst.
    cyc(0, 0, 0, 32'h0, 1, 1, 32'h500, 0, 32'h0, W_DMA);
    cyc(1, 1, 0, 32'h20, 1, 0, 32'h504, 0, 32'h9999_9999, W_NONE);
    chk("midrst_dma_gnt",    {31'd0, bus.dma_gnt},    32'd0);
    chk("midrst_cpu_stall",  {31'd0, bus.cpu_stall},  32'd0);
    chk("midrst_mem_we",     {31'd0, bus.mem_we},     32'd0);
    chk("midrst_dma_rvalid", {31'd0, bus.dma_rvalid}, 32'd0);
    cyc(0, 1, 1, 32'h20, 1, 0, 32'h504, 0, 32'hAAAA_AAAA, W_CPU);
    chk("postrst_dma_rvalid", {31'd0, bus.dma_rvalid}, 32'd0);
    cyc(0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, W_NONE);
    cyc(0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, W_NONE);
    cyc(0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, W_NONE);

    chk("acc_q_left", acc_q.size(), 32'd0);
    chk("rd_q_left",  rd_q.size(),  32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
